// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus memory-map constants and the OAM DMA state type.
package cpu_bus_pkg;

  localparam logic [15:0] RAM_END     = 16'h1FFF;
  localparam logic [15:0] PPU_BASE    = 16'h2000;
  localparam logic [15:0] PPU_END     = 16'h3FFF;
  localparam logic [15:0] OAMDMA_ADDR = 16'h4014;
  localparam logic [15:0] PRG_BASE    = 16'h8000;
  localparam logic [2:0]  OAMDATA_IDX = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    DUMMY,
    READ,
    WRITE
  } dma_state_t;

endpackage

// File: rtl/cpu_oam_dma.sv
// OAM DMA engine: page/index sequencing, byte staging and CPU stall (rdy).
module cpu_oam_dma
  import cpu_bus_pkg::*;
(
  input  logic        clk_ph2,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  start_page,
  input  logic [7:0]  rd_byte,
  output logic        rdy,
  output logic        dma_rd,
  output logic        dma_wr,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_byte
);

  dma_state_t state_q, state_d;
  logic       parity_q;
  logic [7:0] page_q;
  logic [7:0] idx_q;
  logic [7:0] byte_q;

  always_ff @(posedge clk_ph2 or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // An odd-cycle start spends one extra ALIGN cycle before the dummy cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = parity_q ? ALIGN : DUMMY;
      ALIGN:   state_d = DUMMY;
      DUMMY:   state_d = READ;
      READ:    state_d = WRITE;
      WRITE:   state_d = (idx_q == 8'hFF) ? IDLE : READ;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdy    = (state_q == IDLE);
    dma_rd = (state_q == READ);
    dma_wr = (state_q == WRITE);
  end

  always_ff @(posedge clk_ph2 or negedge rst) begin
    if (!rst) begin
      parity_q <= 1'b0;
      page_q   <= '0;
      idx_q    <= '0;
      byte_q   <= '0;
    end else begin
      parity_q <= ~parity_q;
      if (state_q == IDLE && start) page_q <= start_page;
      if (state_q == DUMMY)         idx_q  <= '0;
      if (state_q == WRITE)         idx_q  <= idx_q + 8'd1;
      if (state_q == READ)          byte_q <= rd_byte;
    end
  end

  assign dma_addr = {page_q, idx_q};
  assign dma_byte = byte_q;

endmodule

// File: rtl/cpu_bus_responder.sv
// 6502-side bus responder: NES memory map decode, internal RAM, PRG ROM,
// PPU register port and OAM DMA.
module cpu_bus_responder
  import cpu_bus_pkg::*;
#(
  parameter int unsigned RAM_AW         = 11,
  parameter int unsigned PRG_AW         = 15,
  parameter int unsigned PRG_MIRROR_16K = 0
) (
  input  logic              clk_ph2,
  input  logic              rst,
  input  logic [15:0]       Addr_bus,
  input  logic              rw,
  input  logic [7:0]        Data_wr,
  output logic [7:0]        Data_bus,
  output logic              rdy,
  output logic              ppu_cs,
  output logic [2:0]        ppu_addr,
  output logic              ppu_we,
  output logic [7:0]        ppu_wdata,
  input  logic [7:0]        ppu_rdata,
  input  logic              prg_ld_en,
  input  logic [PRG_AW-1:0] prg_ld_addr,
  input  logic [7:0]        prg_ld_data
);

  localparam logic [PRG_AW-1:0] PRG_MASK =
    (PRG_MIRROR_16K != 0) ? ~(PRG_AW'(1) << 14) : '1;

  logic [7:0]        ram [2**RAM_AW];
  logic [7:0]        rom [2**PRG_AW];

  logic [15:0]       eff_addr;
  logic              ram_hit, ppu_hit, prg_hit;
  logic [RAM_AW-1:0] ram_idx;
  logic [PRG_AW-1:0] rom_idx;
  logic [7:0]        rd_byte;
  logic              dma_start, dma_rd, dma_wr;
  logic [15:0]       dma_addr;
  logic [7:0]        dma_byte;

  assign dma_start = rdy && !rw && (Addr_bus == OAMDMA_ADDR);

  cpu_oam_dma u_dma (
    .clk_ph2    (clk_ph2),
    .rst        (rst),
    .start      (dma_start),
    .start_page (Data_wr),
    .rd_byte    (rd_byte),
    .rdy        (rdy),
    .dma_rd     (dma_rd),
    .dma_wr     (dma_wr),
    .dma_addr   (dma_addr),
    .dma_byte   (dma_byte)
  );

  // The CPU owns the decoder while rdy=1; the DMA source address otherwise.
  always_comb begin
    eff_addr = rdy ? Addr_bus : dma_addr;
    ram_hit  = (eff_addr <= RAM_END);
    ppu_hit  = (eff_addr >= PPU_BASE) && (eff_addr <= PPU_END);
    prg_hit  = (eff_addr >= PRG_BASE);
    ram_idx  = eff_addr[RAM_AW-1:0];
    rom_idx  = eff_addr[PRG_AW-1:0] & PRG_MASK;
    rd_byte  = '0;
    if (ram_hit)      rd_byte = ram[ram_idx];
    else if (ppu_hit) rd_byte = ppu_rdata;
    else if (prg_hit) rd_byte = rom[rom_idx];
  end

  always_comb begin
    ppu_cs    = 1'b0;
    ppu_we    = 1'b0;
    ppu_addr  = '0;
    ppu_wdata = '0;
    if (rst) begin
      if (dma_wr) begin
        ppu_cs    = 1'b1;
        ppu_we    = 1'b1;
        ppu_addr  = OAMDATA_IDX;
        ppu_wdata = dma_byte;
      end else if (dma_rd && ppu_hit) begin
        ppu_cs   = 1'b1;
        ppu_addr = eff_addr[2:0];
      end else if (rdy && ppu_hit) begin
        ppu_cs    = 1'b1;
        ppu_we    = ~rw;
        ppu_addr  = Addr_bus[2:0];
        ppu_wdata = Data_wr;
      end
    end
  end

  always_ff @(posedge clk_ph2) begin
    if (rdy && !rw && (Addr_bus <= RAM_END)) ram[Addr_bus[RAM_AW-1:0]] <= Data_wr;
  end

  always_ff @(posedge clk_ph2) begin
    if (prg_ld_en) rom[prg_ld_addr] <= prg_ld_data;
  end

  always_ff @(posedge clk_ph2 or negedge rst) begin
    if (!rst)            Data_bus <= '0;
    else if (rdy && rw)  Data_bus <= rd_byte;
  end

endmodule

// File: doc/cpu_bus_responder.md
Name: cpu_bus_responder

Overview:
- Memory/peripheral responder on the 6502 CPU bus. It is the other end of the CPU's Addr_bus/Data_bus interface.
- Decodes the NES CPU memory map and serves the following:
  - 2 KB internal RAM, mirrored.
  - PPU register window, forwarded to a PPU port.
  - PRG ROM, loaded through a side port.
  - OAM DMA engine at $4014, which stalls the CPU through rdy.
- Replaces bench-level combinational memory models in system integration.

Parameters:
RAM_AW, 11, internal RAM address width (2 KB).
PRG_AW, 15, PRG ROM address width (32 KB).
PRG_MIRROR_16K, 0, 1 = only 16 KB present; $C000-$FFFF mirrors $8000-$BFFF.

Ports:
clk_ph2  in  1  single system clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset.
Addr_bus  in  16  CPU address.
rw  in  1  1 = CPU read, 0 = CPU write.
Data_wr  in  8  CPU write data.
Data_bus  out  8  read data to CPU, registered.
rdy  out  1  1 = CPU may proceed; 0 = CPU must hold (DMA active).
ppu_cs  out  1  one-cycle strobe for a PPU register access.
ppu_addr  out  3  PPU register index.
ppu_we  out  1  write qualifier for ppu_cs.
ppu_wdata  out  8  PPU write data.
ppu_rdata  in  8  PPU read data, valid in the same cycle as ppu_cs.
prg_ld_en  in  1  PRG load write enable.
prg_ld_addr  in  PRG_AW  PRG load address.
prg_ld_data  in  8  PRG load data.

Behaviour:
- Reset state (rst=0, asynchronous):
  - Data_bus=0, rdy=1, ppu_cs=0, ppu_we=0, ppu_addr=0, ppu_wdata=0.
  - DMA FSM=IDLE, parity bit=0.
  - RAM and ROM contents are not cleared.
- Decode, applied when rdy=1:
  - $0000-$1FFF: RAM[Addr_bus[RAM_AW-1:0]].
  - $2000-$3FFF: PPU register Addr_bus[2:0].
  - $4014 write: start DMA.
  - $8000-$FFFF: ROM[Addr_bus[PRG_AW-1:0]]; with PRG_MIRROR_16K=1, bit 14 is forced to 0.
  - All other addresses: reads return 8'h00, writes are ignored.
- Read latency: 1 cycle. Data_bus is updated on the edge after Addr_bus is sampled with rw=1. Data_bus holds its value when rw=0.
- RAM write: takes effect at the sampling edge. A read of the same address in the next cycle returns the new value.
- ROM: writable only via prg_ld_en, which is accepted in any state. CPU writes to $8000+ are ignored.
- PPU access, same cycle as the sample:
  - ppu_cs=1 for exactly one cycle; ppu_we=~rw.
  - ppu_addr=Addr_bus[2:0]; ppu_wdata=Data_wr.
  - On a read, ppu_rdata is captured into Data_bus at that edge.
- Parity bit toggles every cycle after reset.
- DMA FSM states:
  - IDLE:
    - A $4014 write latches page=Data_wr and sets rdy=0 next cycle.
    - Goes to ALIGN if parity=1 at the write edge, else goes to DUMMY.
  - ALIGN: 1 cycle, then DUMMY.
  - DUMMY: 1 cycle; clears idx=0, then READ.
  - READ: internally reads byte {page,idx} through the same decode (RAM/ROM/zero; a PPU-range source reads via ppu_cs with ppu_we=0). Latches the byte, then WRITE.
  - WRITE:
    - Drives ppu_cs=1, ppu_we=1, ppu_addr=3'd4, ppu_wdata=byte.
    - idx increments with 8-bit wrap.
    - If idx was 8'hFF, goes to IDLE and rdy=1 next cycle; else goes to READ.
- DMA timing: total stall (rdy=0) is 513 cycles (even start) or 514 cycles (odd start).
- Bus handling during DMA:
  - Addr_bus/rw/Data_wr are ignored while rdy=0.
  - Data_bus holds its last CPU-visible value.
  - A $4014 write while DMA is active is ignored.
- Simultaneous events: a prg_ld_en write and a CPU/DMA ROM read of the same address in one cycle return the old byte.
- Reset mid-DMA: FSM goes to IDLE, rdy=1 immediately (asynchronously), no further ppu_cs.

Decomposition:
- Shared package cpu_bus_pkg holds:
  - Region base/mask constants: RAM_END, PPU_BASE, PPU_END, OAMDMA_ADDR=16'h4014, PRG_BASE, OAMDATA_IDX=3'd4.
  - DMA state enum: IDLE, ALIGN, DUMMY, READ, WRITE.
- One sub-module, cpu_oam_dma: the FSM, page/idx counters and rdy generation.
- The top level keeps decode, the RAM/ROM arrays and the PPU port mux.

Test Plan:
1. RAM mirror: write 8'h5A to $0005, then read $0805 and $1805 -> Data_bus=8'h5A one cycle after each address.
2. PPU window: write 8'h3C to $3FF9 -> one-cycle ppu_cs=1, ppu_we=1, ppu_addr=1, ppu_wdata=8'h3C. Read $2002 with ppu_rdata=8'h80 -> Data_bus=8'h80.
3. ROM load and mirror:
   - Load prg_ld_addr=15'h3FFC with 8'h34, PRG_MIRROR_16K=1.
   - Read $FFFC and $BFFC -> 8'h34 both.
   - CPU write 8'hFF to $FFFC, then read $FFFC -> still 8'h34.
4. OAM DMA, even start: preload RAM $0200+i=i, write 8'h02 to $4014 -> rdy=0 for exactly 513 cycles; 256 ppu writes with ppu_addr=4 and data 0..255 in order; rdy=1 afterwards.
5. DMA odd start: same as scenario 4 issued one cycle later -> stall of 514 cycles. A $4014 write issued mid-DMA is ignored (write count stays 256).
6. Reset mid-DMA: assert rst=0 at write #100 -> rdy=1 immediately, no further ppu_cs. Unmapped read of $5000 after reset release -> Data_bus=8'h00.
